cond_issue_unit: RTL and testbench

- Issue stage that sits directly upstream of the condition tester and drives it.
- Captures one instruction from fetch/decode and presents its condition field (IR[31:28]) to the condition tester.
- Waits until the flag register holds the flags of all older flag-setting instructions, then samples the tester's Cond result.
- Hands the instruction to execute with a pass/squash bit, inserts flush bubbles after a taken branch, and counts squashed instructions.

---
 rtl/cond_issue_unit_pkg.sv | 44 ++++
 rtl/cond_issue_unit_sat_counter.sv | 20 ++
 rtl/cond_issue_unit.sv | 108 ++++++++++
 tb/tb_cond_issue_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cond_issue_unit_pkg.sv
// Shared types and field constants for the conditional issue stage.
package cond_issue_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    ISSUE = 2'd2,
    FLUSH = 2'd3
  } state_t;

  // Condition codes carried in ir[31:28]
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  // Instruction field positions
  localparam logic [2:0] OPC_BRANCH = 3'b101;
  localparam int         S_BIT      = 20;
  localparam int         COND_MSB   = 31;
  localparam int         COND_LSB   = 28;

  // Branch: opcode class bits [27:25] equal 101
  function automatic logic is_branch_f(input logic [31:0] w);
    return w[27:25] == OPC_BRANCH;
  endfunction

  // Data-processing instruction with the S bit set updates the flags
  function automatic logic sets_flags_f(input logic [31:0] w);
    return (w[27:26] == 2'b00) && w[S_BIT];
  endfunction

endpackage

// File: rtl/cond_issue_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Clear has priority; increment stops once every bit is set
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/cond_issue_unit.sv
// Issue stage in front of the condition tester: holds one instruction,
// waits for stable flags, samples Cond, offers pass/squash to execute and
// discards the fetch shadow of a taken branch.
module cond_issue_unit
  import cond_issue_unit_pkg::*;
#(
  parameter int unsigned FLUSH_DEPTH = 1,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ir_valid,
  input  logic [31:0]      ir,
  output logic             ir_ready,
  output logic [3:0]       cond_field,
  input  logic             cond,
  input  logic             fr_ld,
  output logic             exec_valid,
  output logic [31:0]      exec_ir,
  output logic             exec_pass,
  input  logic             exec_ready,
  output logic [CNT_W-1:0] squash_cnt
);

  localparam int FC_W = (FLUSH_DEPTH < 1) ? 1 : $clog2(FLUSH_DEPTH + 1);

  state_t          state;
  logic [31:0]     held_ir;
  logic [FC_W-1:0] flush_cnt;
  logic            flags_pending;
  logic            is_branch;
  logic            sets_flags;
  logic            issue_hs;

  assign is_branch  = is_branch_f(held_ir);
  assign sets_flags = sets_flags_f(held_ir);

  assign ir_ready   = (state == IDLE) || (state == FLUSH);
  assign exec_valid = (state == ISSUE);
  assign exec_ir    = held_ir;
  assign cond_field = held_ir[COND_MSB:COND_LSB];
  assign issue_hs   = exec_valid && exec_ready;

  // Issue FSM, held instruction, flag hazard tracking and flush shadow
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      held_ir       <= '0;
      exec_pass     <= 1'b0;
      flush_cnt     <= '0;
      flags_pending <= 1'b0;
    end else begin
      // A passing flag-setter leaving this cycle outranks a flag write
      if (issue_hs && exec_pass && sets_flags) begin
        flags_pending <= 1'b1;
      end else if (fr_ld) begin
        flags_pending <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (ir_valid) begin
            held_ir <= ir;
            state   <= HOLD;
          end
        end
        HOLD: begin
          // A flag write in this very cycle is not yet visible to the tester
          if (!(flags_pending || fr_ld)) begin
            exec_pass <= cond;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (exec_ready) begin
            if (exec_pass && is_branch && (FLUSH_DEPTH > 0)) begin
              flush_cnt <= FC_W'(FLUSH_DEPTH);
              state     <= FLUSH;
            end else begin
              state <= IDLE;
            end
          end
        end
        FLUSH: begin
          if (ir_valid) begin
            if (flush_cnt <= FC_W'(1)) begin
              flush_cnt <= '0;
              state     <= IDLE;
            end else begin
              flush_cnt <= flush_cnt - FC_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_squash_cnt (
    .clk  (clk),
    .clear(!reset_n),
    .inc  (issue_hs && !exec_pass),
    .cnt  (squash_cnt)
  );

endmodule

// File: tb/tb_cond_issue_unit.sv
// Directed bench for cond_issue_unit; a second narrow-counter instance
// shares the stimulus to observe counter saturation.
module tb_cond_issue_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ir_valid;
  logic [31:0] ir;
  logic        cond;
  logic        fr_ld;
  logic        exec_ready;

  logic        ir_ready, exec_valid, exec_pass;
  logic [3:0]  cond_field;
  logic [31:0] exec_ir;
  logic [15:0] squash_cnt;

  logic        s_ir_ready, s_exec_valid, s_exec_pass;
  logic [3:0]  s_cond_field;
  logic [31:0] s_exec_ir;
  logic [1:0]  s_squash_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cond_issue_unit #(.FLUSH_DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .ir_valid(ir_valid), .ir(ir),
    .ir_ready(ir_ready), .cond_field(cond_field), .cond(cond), .fr_ld(fr_ld),
    .exec_valid(exec_valid), .exec_ir(exec_ir), .exec_pass(exec_pass),
    .exec_ready(exec_ready), .squash_cnt(squash_cnt)
  );

  cond_issue_unit #(.FLUSH_DEPTH(2), .CNT_W(2)) dut_small (
    .clk(clk), .reset_n(reset_n), .ir_valid(ir_valid), .ir(ir),
    .ir_ready(s_ir_ready), .cond_field(s_cond_field), .cond(cond), .fr_ld(fr_ld),
    .exec_valid(s_exec_valid), .exec_ir(s_exec_ir), .exec_pass(s_exec_pass),
    .exec_ready(exec_ready), .squash_cnt(s_squash_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Capture, sample and hand off one instruction with no flag hazard
  task automatic run_instr(input string tag, input logic [31:0] w,
                           input logic c, input logic exp_pass);
    ir_valid = 1'b1; ir = w; cond = c; exec_ready = 1'b1;
    tick();
    ir_valid = 1'b0;
    check({tag, " hold ir_ready"}, ir_ready, 0);
    check({tag, " cond_field"}, cond_field, w[31:28]);
    check({tag, " hold exec_valid"}, exec_valid, 0);
    tick();
    check({tag, " issue exec_valid"}, exec_valid, 1);
    check({tag, " exec_pass"}, exec_pass, exp_pass);
    check({tag, " exec_ir"}, exec_ir, w);
    tick();
    check({tag, " done exec_valid"}, exec_valid, 0);
  endtask

  initial begin
    reset_n = 1'b0; ir_valid = 1'b0; ir = '0; cond = 1'b0;
    fr_ld = 1'b0; exec_ready = 1'b0;

    // Reset state
    tick(); tick();
    check("rst ir_ready", ir_ready, 1);
    check("rst exec_valid", exec_valid, 0);
    check("rst cond_field", cond_field, 0);
    check("rst squash_cnt", squash_cnt, 0);
    check("rst flags_pending", dut.flags_pending, 0);
    reset_n = 1'b1;

    // Basic pass
    run_instr("al_add", 32'hE0810002, 1'b1, 1'b1);
    check("al_add ir_ready", ir_ready, 1);
    check("al_add squash_cnt", squash_cnt, 0);

    // Squash counting and saturation of the 2-bit instance
    for (int i = 0; i < 3; i++) run_instr("eq_sq", 32'h00810002, 1'b0, 1'b0);
    check("squash x3", squash_cnt, 3);
    check("small x3", s_squash_cnt, 3);
    for (int i = 0; i < 2; i++) run_instr("eq_sq", 32'h00810002, 1'b0, 1'b0);
    check("squash x5", squash_cnt, 5);
    check("small saturated", s_squash_cnt, 3);

    // Flag hazard: ADDS passes, following NE waits for the flag write
    run_instr("adds", 32'hE0910002, 1'b1, 1'b1);
    check("adds pending", dut.flags_pending, 1);
    ir_valid = 1'b1; ir = 32'h10810002; cond = 1'b1;
    tick();
    ir_valid = 1'b0;
    tick();
    check("haz wait1", exec_valid, 0);
    tick();
    check("haz wait2", exec_valid, 0);
    fr_ld = 1'b1;
    tick();
    check("haz fr_ld clears", dut.flags_pending, 0);
    check("haz wait3", exec_valid, 0);
    tick();
    check("haz same-cycle fr_ld", exec_valid, 0);
    fr_ld = 1'b0; cond = 1'b0;
    tick();
    check("haz issue", exec_valid, 1);
    check("haz pass from late cond", exec_pass, 0);
    tick();
    check("haz squash_cnt", squash_cnt, 6);

    // Set wins over clear on the same edge
    ir_valid = 1'b1; ir = 32'hE0910002; cond = 1'b1; exec_ready = 1'b0;
    tick();
    ir_valid = 1'b0;
    tick();
    fr_ld = 1'b1; exec_ready = 1'b1;
    tick();
    check("set wins", dut.flags_pending, 1);
    tick();
    check("clear later", dut.flags_pending, 0);
    fr_ld = 1'b0;

    // A squashed flag-setter leaves flags_pending clear
    run_instr("sq_fs", 32'h00910002, 1'b0, 1'b0);
    check("sq_fs pending", dut.flags_pending, 0);
    check("sq_fs squash_cnt", squash_cnt, 7);

    // Taken branch: two fetches dropped, the third issued
    run_instr("br", 32'hEA000004, 1'b1, 1'b1);
    check("br flush_cnt", dut.flush_cnt, 2);
    check("br ir_ready", ir_ready, 1);
    ir_valid = 1'b1; ir = 32'h11111111;
    tick();
    check("drop1 exec_valid", exec_valid, 0);
    check("drop1 cond_field", cond_field, 4'hE);
    ir_valid = 1'b0;
    tick();
    check("flush idle hold", dut.flush_cnt, 1);
    ir_valid = 1'b1; ir = 32'h22222222;
    tick();
    check("drop2 exec_valid", exec_valid, 0);
    check("drop2 ir_ready", ir_ready, 1);
    ir = 32'hE0A00003;
    tick();
    ir_valid = 1'b0;
    check("third captured", cond_field, 4'hE);
    check("third ir_ready", ir_ready, 0);
    tick();
    check("third exec_valid", exec_valid, 1);
    check("third exec_ir", exec_ir, 32'hE0A00003);
    tick();

    // Squashed branch does not flush
    run_instr("br_sq", 32'hEA000004, 1'b0, 1'b0);
    run_instr("after_br_sq", 32'hE0810002, 1'b1, 1'b1);
    check("br_sq squash_cnt", squash_cnt, 8);

    // Backpressure in ISSUE
    ir_valid = 1'b1; ir = 32'hE0810002; cond = 1'b1; exec_ready = 1'b0;
    tick();
    ir_valid = 1'b0;
    tick();
    cond = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("bp exec_valid", exec_valid, 1);
      check("bp exec_ir", exec_ir, 32'hE0810002);
      check("bp exec_pass", exec_pass, 1);
      check("bp ir_ready", ir_ready, 0);
      if (i < 3) tick();
    end
    exec_ready = 1'b1;
    tick();
    check("bp done", exec_valid, 0);
    check("bp squash_cnt", squash_cnt, 8);

    // Reset during ISSUE with a squash handshake pending
    ir_valid = 1'b1; ir = 32'h00810002; cond = 1'b0; exec_ready = 1'b0;
    tick();
    ir_valid = 1'b0;
    tick();
    check("rst_iss in issue", exec_valid, 1);
    exec_ready = 1'b1; reset_n = 1'b0;
    tick();
    check("rst_iss exec_valid", exec_valid, 0);
    check("rst_iss squash_cnt", squash_cnt, 0);
    check("rst_iss ir_ready", ir_ready, 1);
    reset_n = 1'b1;

    // Reset during FLUSH
    run_instr("br2", 32'hEA000004, 1'b1, 1'b1);
    check("br2 flush_cnt", dut.flush_cnt, 2);
    reset_n = 1'b0;
    tick();
    check("rst_fl flush_cnt", dut.flush_cnt, 0);
    check("rst_fl ir_ready", ir_ready, 1);
    reset_n = 1'b1;
    run_instr("post_rst", 32'hE0810002, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
